// File: rtl/wb_write_queue.sv
// wb_write_queue
//
// Write-back queue that owns the single GRF write port. Results from the
// primary write-back path (never stalls) and the secondary MDU path are
// merged into one in-order circular FIFO and drained one write per cycle
// onto the GRF. A lookup port lets decode-stage forwarding see writes that
// are still waiting in the queue.
//
// Ports
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   PriValid/PriWA/PriWD    primary result, always accepted
//   SecValid/SecWA/SecWD    MDU result, accepted when SecReady is high
//   SecReady                room for a secondary entry on top of a primary one
//   RegWrite/WA/WD          GRF write port, driven from the FIFO head
//   LookupRA                register being read by decode
//   LookupHit/LookupWD      youngest pending write to LookupRA
//   Count                   number of occupied entries
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       PriValid,
    input  logic [4:0]                 PriWA,
    input  logic [31:0]                PriWD,
    input  logic                       SecValid,
    output logic                       SecReady,
    input  logic [4:0]                 SecWA,
    input  logic [31:0]                SecWD,
    output logic                       RegWrite,
    output logic [4:0]                 WA,
    output logic [31:0]                WD,
    input  logic [4:0]                 LookupRA,
    output logic                       LookupHit,
    output logic [31:0]                LookupWD,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic [4:0]    wa_q [DEPTH];
    logic [4:0]    wa_d [DEPTH];
    logic [31:0]   wd_q [DEPTH];
    logic [31:0]   wd_d [DEPTH];

    logic          pri_enq;
    logic          sec_fire;
    logic          sec_enq;
    logic          deq;
    logic [PW-1:0] sec_slot;
    // One bit wider than Count so an impossible overflow stays visible.
    logic [SW-1:0] count_sum;

    logic [PW-1:0] lk_idx;

    // Enqueue / dequeue decisions and next-state pointers
    always_comb begin
        // Writes to r0 never enter the queue; a secondary r0 write is still
        // consumed through the handshake so the MDU is not left waiting.
        pri_enq   = PriValid && (PriWA != 5'd0);
        // Keeping one slot in reserve means a primary write always fits.
        SecReady  = (count_q <= CW'(DEPTH - 2));
        sec_fire  = SecValid && SecReady;
        sec_enq   = sec_fire && (SecWA != 5'd0);
        deq       = (count_q != '0);

        // Secondary lands behind the primary when both enqueue together.
        sec_slot  = wr_ptr_q + PW'(pri_enq);

        count_sum = {1'b0, count_q} + SW'(pri_enq) + SW'(sec_enq) - SW'(deq);
        count_d   = count_sum[CW-1:0];
        wr_ptr_d  = wr_ptr_q + PW'(pri_enq) + PW'(sec_enq);
        rd_ptr_d  = rd_ptr_q + PW'(deq);

        wa_d = wa_q;
        wd_d = wd_q;
        if (pri_enq) begin
            wa_d[wr_ptr_q] = PriWA;
            wd_d[wr_ptr_q] = PriWD;
        end
        if (sec_enq) begin
            wa_d[sec_slot] = SecWA;
            wd_d[sec_slot] = SecWD;
        end
    end

    // Control state: pointers and occupancy. Entry validity is implied by
    // Count and the read pointer, so clearing these invalidates every slot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (count_sum <= SW'(DEPTH));
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload storage; only meaningful where Count marks it valid.
    always_ff @(posedge Clock) begin
        wa_q <= wa_d;
        wd_q <= wd_d;
    end

    // GRF port straight from the head entry
    always_comb begin
        RegWrite = deq;
        WA       = deq ? wa_q[rd_ptr_q] : 5'd0;
        WD       = deq ? wd_q[rd_ptr_q] : 32'd0;
        Count    = count_q;
    end

    // Forwarding lookup: scan oldest to youngest so the youngest match
    // overrides any older one. Same-cycle inputs are deliberately ignored.
    always_comb begin
        LookupHit = 1'b0;
        LookupWD  = 32'd0;
        lk_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (LookupRA != 5'd0) &&
                (wa_q[lk_idx] == LookupRA)) begin
                LookupHit = 1'b1;
                LookupWD  = wd_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic        Clock;
    logic        Reset;
    logic        PriValid;
    logic [4:0]  PriWA;
    logic [31:0] PriWD;
    logic        SecValid;
    logic        SecReady;
    logic [4:0]  SecWA;
    logic [31:0] SecWD;
    logic        RegWrite;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  LookupRA;
    logic        LookupHit;
    logic [31:0] LookupWD;
    logic [$clog2(DEPTH):0] Count;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .PriValid (PriValid),
        .PriWA    (PriWA),
        .PriWD    (PriWD),
        .SecValid (SecValid),
        .SecReady (SecReady),
        .SecWA    (SecWA),
        .SecWD    (SecWD),
        .RegWrite (RegWrite),
        .WA       (WA),
        .WD       (WD),
        .LookupRA (LookupRA),
        .LookupHit(LookupHit),
        .LookupWD (LookupWD),
        .Count    (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs the queue must show given the pending writes in the model.
    task automatic check_model();
        logic        e_hit;
        logic [31:0] e_lwd;
        int          n;
        n     = mq.size();
        e_hit = 1'b0;
        e_lwd = 32'd0;
        if (LookupRA != 5'd0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (mq[i].wa == LookupRA) begin
                    e_hit = 1'b1;
                    e_lwd = mq[i].wd;
                    break;
                end
            end
        end
        chk("regwrite", {31'd0, RegWrite}, (n != 0) ? 32'd1 : 32'd0);
        chk("wa", {27'd0, WA}, (n != 0) ? {27'd0, mq[0].wa} : 32'd0);
        chk("wd", WD, (n != 0) ? mq[0].wd : 32'd0);
        chk("count", 32'(Count), 32'(n));
        chk("count_bound", (32'(Count) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
        chk("secready", {31'd0, SecReady}, (n <= DEPTH - 2) ? 32'd1 : 32'd0);
        chk("lookuphit", {31'd0, LookupHit}, {31'd0, e_hit});
        chk("lookupwd", LookupWD, e_lwd);
    endtask

    task automatic model_update(input logic pv, input logic [4:0] pwa, input logic [31:0] pwd,
                                input logic sv, input logic [4:0] swa, input logic [31:0] swd);
        bit   rdy;
        ent_t e;
        rdy = (mq.size() <= DEPTH - 2);
        if (mq.size() > 0) void'(mq.pop_front());
        if (pv && pwa != 5'd0) begin
            e.wa = pwa; e.wd = pwd; mq.push_back(e);
        end
        if (sv && rdy && swa != 5'd0) begin
            e.wa = swa; e.wd = swd; mq.push_back(e);
        end
    endtask

    // Drive one cycle, check against the model, then cross the rising edge.
    task automatic step(input logic pv, input logic [4:0] pwa, input logic [31:0] pwd,
                        input logic sv, input logic [4:0] swa, input logic [31:0] swd,
                        input logic [4:0] ra);
        PriValid = pv; PriWA = pwa; PriWD = pwd;
        SecValid = sv; SecWA = swa; SecWD = swd;
        LookupRA = ra;
        #1;
        check_model();
        model_update(pv, pwa, pwd, sv, swa, swd);
        @(negedge Clock);
    endtask

    task automatic idle(input logic [4:0] ra);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra);
    endtask

    task automatic peek(input logic [4:0] ra);
        PriValid = 1'b0; SecValid = 1'b0; LookupRA = ra;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0;
        PriValid = 1'b0; PriWA = '0; PriWD = '0;
        SecValid = 1'b0; SecWA = '0; SecWD = '0;
        LookupRA = '0;

        // Reset held for two cycles
        @(negedge Clock);
        #1;
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_wa", {27'd0, WA}, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_secready", {31'd0, SecReady}, 32'd1);
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(5'd0);
            chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
        end

        // Single primary write
        step(1'b1, 5'd5, 32'h6, 1'b0, 5'd0, 32'd0, 5'd5);
        peek(5'd5);
        chk("single_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("single_wa", {27'd0, WA}, 32'd5);
        chk("single_wd", WD, 32'h6);
        chk("single_lookup", LookupWD, 32'h6);
        idle(5'd5);
        peek(5'd5);
        chk("single_after_rw", {31'd0, RegWrite}, 32'd0);
        chk("single_after_cnt", 32'(Count), 32'd0);

        // Dual enqueue to the same register, primary first
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3);
        peek(5'd3);
        chk("dual_wd0", WD, 32'h11);
        chk("dual_cnt", 32'(Count), 32'd2);
        chk("dual_lookup0", LookupWD, 32'h22);
        idle(5'd3);
        peek(5'd3);
        chk("dual_wa1", {27'd0, WA}, 32'd3);
        chk("dual_wd1", WD, 32'h22);
        chk("dual_lookup1", LookupWD, 32'h22);
        idle(5'd3);

        // Backpressure and pointer wrap
        for (int i = 0; i < 6; i++) begin
            if (mq.size() == DEPTH - 1) begin
                peek(5'd1);
                chk("bp_secready_low", {31'd0, SecReady}, 32'd0);
            end
            step(1'b1, 5'(2 * i + 1), 32'h100 + 32'(i), 1'b1, 5'(2 * i + 2), 32'h200 + 32'(i),
                 5'(2 * i + 1));
        end
        chk("bp_full_cnt", 32'(Count), 32'd3);
        for (int i = 0; i < 5; i++) idle(5'(i + 9));

        // Register-0 filter
        peek(5'd0);
        chk("r0_secready", {31'd0, SecReady}, 32'd1);
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h1234, 5'd0);
        peek(5'd0);
        chk("r0_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("r0_count", 32'(Count), 32'd0);
        chk("r0_lookuphit", {31'd0, LookupHit}, 32'd0);

        // Reset between edges with three entries pending
        step(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd7);
        step(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd7);
        peek(5'd7);
        chk("mid_cnt_before", 32'(Count), 32'd3);
        #1 Reset = 1'b0;
        #1;
        chk("mid_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("mid_wa", {27'd0, WA}, 32'd0);
        chk("mid_wd", WD, 32'd0);
        chk("mid_count", 32'(Count), 32'd0);
        chk("mid_lookuphit", {31'd0, LookupHit}, 32'd0);
        mq.delete();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) idle(5'd9);

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom,
                 ($urandom % 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 6; i++) idle(5'($urandom_range(0, 7)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
